inst_fetch: RTL and testbench

//  Fetch-side initiator for the instruction ROM port: owns the PC, drives rom_inst_en/rom_inst_addr,

---
 rtl/inst_fetch_pkg.sv | 28 ++
 rtl/inst_fetch_pc_next_sel.sv | 30 +++
 rtl/inst_fetch.sv | 104 ++++++++++
 tb/tb_inst_fetch.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset/NOP constants and IF/ID register layout for the fetch stage.
// Imported by the fetch top and its next-PC selector.
package inst_fetch_pkg;

    localparam int InstAddrWidth = 32;
    localparam int InstWidth     = 32;

    localparam logic [InstAddrWidth-1:0] RESET_PC = 32'h1c00_0000;
    localparam logic [InstWidth-1:0]     NOP_INST = 32'h0340_0000;
    localparam logic [InstAddrWidth-1:0] PC_STEP  = 32'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [InstAddrWidth-1:0] pc;
        logic [InstWidth-1:0]     inst;
        logic                     valid;
        logic                     adef;
    } id_reg_t;

    function automatic logic pc_aligned(input logic [InstAddrWidth-1:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_pc_next_sel.sv
// Next-PC priority mux: flush > unstalled branch > hold (stall or idle) > sequential step.
// Purely combinational; reset is applied by the owning register.
module inst_fetch_pc_next_sel
    import inst_fetch_pkg::*;
#(
    parameter logic [InstAddrWidth-1:0] PC_STEP_P = inst_fetch_pkg::PC_STEP
) (
    input  logic                     i_run,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic [InstAddrWidth-1:0] i_flush_pc,
    input  logic                     i_branch,
    input  logic [InstAddrWidth-1:0] i_branch_target,
    input  logic [InstAddrWidth-1:0] i_pc,
    output logic [InstAddrWidth-1:0] o_pc_next
);

    always_comb begin
        o_pc_next = i_pc;
        if (i_flush) begin
            o_pc_next = i_flush_pc;
        end else if (i_branch && !i_stall) begin
            o_pc_next = i_branch_target;
        end else if (!i_stall && i_run) begin
            // Natural 32-bit overflow gives the 0xFFFFFFFC -> 0 wrap.
            o_pc_next = i_pc + PC_STEP_P;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, drives the ROM port and registers {pc, inst, valid, adef} into IF/ID.
// One-cycle latency, one instruction per cycle; stall holds everything, flush/branch redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = inst_fetch_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = inst_fetch_pkg::NOP_INST,
    parameter logic [31:0] PC_STEP  = inst_fetch_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        rom_inst_en,
    output logic [31:0] rom_inst_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_adef
);

    import inst_fetch_pkg::*;

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    id_reg_t      r_id;
    id_reg_t      w_id_next;
    logic         w_run;
    logic         w_aligned;

    assign w_run     = (r_state == RUN);
    assign w_aligned = pc_aligned(r_pc);

    inst_fetch_pc_next_sel #(
        .PC_STEP_P(PC_STEP)
    ) u_pc_next_sel (
        .i_run          (w_run),
        .i_stall        (stall),
        .i_flush        (flush),
        .i_flush_pc     (flush_pc),
        .i_branch       (branch_flag),
        .i_branch_target(branch_target),
        .i_pc           (r_pc),
        .o_pc_next      (w_pc_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_id_next    = r_id;
        case (r_state)
            IDLE:    w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase

        if (flush) begin
            w_id_next.valid = 1'b0;
            w_id_next.adef  = 1'b0;
            w_id_next.inst  = NOP_INST;
        end else if (!stall) begin
            if (branch_flag) begin
                // The word fetched this cycle is on the wrong path.
                w_id_next.valid = 1'b0;
                w_id_next.adef  = 1'b0;
                w_id_next.inst  = NOP_INST;
            end else if (w_run) begin
                w_id_next.pc    = r_pc;
                w_id_next.inst  = w_aligned ? rom_inst : NOP_INST;
                w_id_next.valid = 1'b1;
                w_id_next.adef  = !w_aligned;
            end else begin
                w_id_next.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_id.pc    <= '0;
            r_id.inst  <= NOP_INST;
            r_id.valid <= 1'b0;
            r_id.adef  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_id    <= w_id_next;
        end
    end

    // Misaligned PCs never reach the ROM; the fault travels down as id_adef.
    assign rom_inst_en   = w_run && w_aligned;
    assign rom_inst_addr = r_pc;
    assign id_pc         = r_id.pc;
    assign id_inst       = r_id.inst;
    assign id_valid      = r_id.valid;
    assign id_adef       = r_id.adef;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: driver queues per-cycle expected outputs, a negedge monitor compares.
`timescale 1ns/1ps
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0340_0000;
    localparam logic [5:0] M_EN = 6'b000001, M_AD = 6'b000010, M_VL = 6'b000100,
                           M_PC = 6'b001000, M_IN = 6'b010000, M_AF = 6'b100000;
    localparam logic [5:0] M_ALL = 6'b111111;
    localparam logic [5:0] M_F   = M_EN | M_AD;
    localparam logic [5:0] M_FV  = M_F | M_VL;

    typedef struct {
        string       name;
        logic [5:0]  m;
        logic        en;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush, branch_flag;
    logic [31:0] flush_pc, branch_target;
    logic        rom_inst_en;
    logic [31:0] rom_inst_addr, rom_inst;
    logic [31:0] id_pc, id_inst;
    logic        id_valid, id_adef;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // External ROM model: word index [13:2] tagged with a constant pattern.
    assign rom_inst = 32'hC0DE_0000 | {20'd0, rom_inst_addr[13:2]};

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .rom_inst_en  (rom_inst_en),
        .rom_inst_addr(rom_inst_addr),
        .rom_inst     (rom_inst),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_valid     (id_valid),
        .id_adef      (id_adef)
    );

    task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.m[0]) cmp(e.name, "en",   {31'd0, rom_inst_en}, {31'd0, e.en});
            if (e.m[1]) cmp(e.name, "addr", rom_inst_addr,        e.addr);
            if (e.m[2]) cmp(e.name, "vld",  {31'd0, id_valid},    {31'd0, e.vld});
            if (e.m[3]) cmp(e.name, "pc",   id_pc,                e.pc);
            if (e.m[4]) cmp(e.name, "inst", id_inst,              e.inst);
            if (e.m[5]) cmp(e.name, "adef", {31'd0, id_adef},     {31'd0, e.adef});
        end
    end

    // Queue the outputs expected during the current cycle, then advance past the next edge.
    task automatic tick(input string nm, input logic [5:0] m, input logic en, input logic [31:0] addr,
                        input logic vld, input logic [31:0] pc, input logic [31:0] inst, input logic adef);
        exp_t e;
        e.name = nm; e.m = m; e.en = en; e.addr = addr; e.vld = vld;
        e.pc = pc; e.inst = inst; e.adef = adef;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        stall = 0; flush = 0; branch_flag = 0;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; branch_flag = 0;
        flush_pc = '0; branch_target = '0;
        @(posedge clk);
        #1;
        tick("rst0", M_ALL, 0, 32'h1c000000, 0, 32'h0, NOP, 0);
        rst = 0;
        tick("rst1", M_ALL, 0, 32'h1c000000, 0, 32'h0, NOP, 0);
        tick("bubble", M_FV, 1, 32'h1c000000, 0, 0, 0, 0);
        tick("first", M_ALL, 1, 32'h1c000004, 1, 32'h1c000000, 32'hC0DE0000, 0);
        stall = 1;
        tick("seq1", M_ALL, 1, 32'h1c000008, 1, 32'h1c000004, 32'hC0DE0001, 0);
        tick("stall1", M_ALL, 1, 32'h1c000008, 1, 32'h1c000004, 32'hC0DE0001, 0);
        tick("stall2", M_ALL, 1, 32'h1c000008, 1, 32'h1c000004, 32'hC0DE0001, 0);
        stall = 0;
        tick("stall3", M_ALL, 1, 32'h1c000008, 1, 32'h1c000004, 32'hC0DE0001, 0);
        tick("resume", M_ALL, 1, 32'h1c00000c, 1, 32'h1c000008, 32'hC0DE0002, 0);
        branch_flag = 1; branch_target = 32'h1c000100;
        tick("pre_br", M_ALL, 1, 32'h1c000010, 1, 32'h1c00000c, 32'hC0DE0003, 0);
        idle_in();
        tick("br_sq", M_FV | M_IN, 1, 32'h1c000100, 0, 0, NOP, 0);
        branch_flag = 1; branch_target = 32'h1c000300; stall = 1;
        tick("br_tgt", M_ALL, 1, 32'h1c000104, 1, 32'h1c000100, 32'hC0DE0040, 0);
        idle_in();
        tick("br_stl", M_ALL, 1, 32'h1c000104, 1, 32'h1c000100, 32'hC0DE0040, 0);
        flush = 1; flush_pc = 32'h1c000200; branch_flag = 1; branch_target = 32'h1c000300; stall = 1;
        tick("pre_fl", M_ALL, 1, 32'h1c000108, 1, 32'h1c000104, 32'hC0DE0041, 0);
        idle_in();
        tick("flush", M_FV | M_IN | M_AF, 1, 32'h1c000200, 0, 0, NOP, 0);
        branch_flag = 1; branch_target = 32'h1c000102;
        tick("fl_tgt", M_ALL, 1, 32'h1c000204, 1, 32'h1c000200, 32'hC0DE0080, 0);
        idle_in();
        tick("mis_br", M_FV, 0, 32'h1c000102, 0, 0, 0, 0);
        tick("adef1", M_ALL, 0, 32'h1c000106, 1, 32'h1c000102, NOP, 1);
        flush = 1; flush_pc = 32'hFFFFFFFC;
        tick("adef2", M_ALL, 0, 32'h1c00010a, 1, 32'h1c000106, NOP, 1);
        idle_in();
        tick("top_pc", M_FV | M_AF, 1, 32'hFFFFFFFC, 0, 0, 0, 0);
        tick("wrap", M_ALL, 1, 32'h00000000, 1, 32'hFFFFFFFC, 32'hC0DE0FFF, 0);
        rst = 1; stall = 1; branch_flag = 1; branch_target = 32'h1c000300;
        tick("post_wr", M_ALL, 1, 32'h00000004, 1, 32'h00000000, 32'hC0DE0000, 0);
        rst = 0; idle_in();
        tick("rst_mid", M_ALL, 0, 32'h1c000000, 0, 32'h0, NOP, 0);
        tick("rst_bub", M_FV, 1, 32'h1c000000, 0, 0, 0, 0);
        tick("rst_run", M_ALL, 1, 32'h1c000004, 1, 32'h1c000000, 32'hC0DE0000, 0);
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
